// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Holds the A (row operand) and B (column operand) matrices for the FP32
// systolic array. On start it streams them onto the left/top array edges with
// the diagonal skew the schedule needs, pads idle lanes with FP32 zero, waits
// a fixed drain interval for the PE pipelines, then pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | buffers writable, outputs zero, waiting for start_i
// S_FEED  | presenting feed step t_q (0 .. 2N-2) on the edge buses
// S_DRAIN | outputs zero, busy high, drain_q counts down to zero
// S_FIN   | one-cycle done pulse, then back to S_IDLE
module systolic_skew_feeder #(
  parameter int N     = 4,
  parameter int DRAIN = 16,
  parameter int IW    = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic            wr_sel_i,
  input  logic [IW-1:0]   wr_row_i,
  input  logic [IW-1:0]   wr_col_i,
  input  logic [31:0]     wr_data_i,
  input  logic            start_i,
  output logic [N*32-1:0] out_left_o,
  output logic [N*32-1:0] out_top_o,
  output logic            feed_valid_o,
  output logic            busy_o,
  output logic            done_o
);

  // Feed step counter must hold 0 .. 2N-1; drain counter holds DRAIN-1 .. 0.
  localparam int TW = $clog2(2 * N);
  localparam int DW = $clog2(DRAIN + 1);
  localparam logic [TW-1:0] T_LAST     = TW'(2 * N - 2);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [DW-1:0]   drain_q;
  logic [N*32-1:0] out_left_q;
  logic [N*32-1:0] out_top_q;
  logic            feed_valid_q;
  logic            busy_q;
  logic            done_q;

  logic [31:0]     a_buf_q [N][N];
  logic [31:0]     b_buf_q [N][N];
  logic [31:0]     a_buf_d [N][N];
  logic [31:0]     b_buf_d [N][N];

  logic            wr_ok;
  logic [TW-1:0]   step_d;
  logic [N*32-1:0] skew_left;
  logic [N*32-1:0] skew_top;

  // Out-of-range indices (only possible when N is not a power of two) are dropped.
  assign wr_ok = wr_en_i && (state_q == S_IDLE) &&
                 (int'(wr_row_i) < N) && (int'(wr_col_i) < N);

  // Buffer next-state with the pending write folded in, so a write in the
  // same cycle as start is already visible to feed step 0.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_ok) begin
      if (wr_sel_i) b_buf_d[wr_row_i][wr_col_i] = wr_data_i;
      else          a_buf_d[wr_row_i][wr_col_i] = wr_data_i;
    end
  end

  // Operand buffer storage, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf_q[r][c] <= '0;
          b_buf_q[r][c] <= '0;
        end
      end
    end else begin
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
    end
  end

  // Feed step that will be on the buses after the next edge.
  always_comb begin
    step_d = (state_q == S_IDLE) ? '0 : t_q + TW'(1);
  end

  // Diagonal skew: lane i carries element (step - i) of its row/column, or zero.
  always_comb begin
    skew_left = '0;
    skew_top  = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(step_d) >= i) && (int'(step_d) - i < N)) begin
        skew_left[i*32 +: 32] = a_buf_d[i][IW'(int'(step_d) - i)];
        skew_top[i*32 +: 32]  = b_buf_d[IW'(int'(step_d) - i)][i];
      end
    end
  end

  // Sequencer with registered outputs; outputs default to zero every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      drain_q      <= '0;
      out_left_q   <= '0;
      out_top_q    <= '0;
      feed_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      out_left_q   <= '0;
      out_top_q    <= '0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_FEED;
            t_q          <= '0;
            out_left_q   <= skew_left;
            out_top_q    <= skew_top;
            feed_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_FEED: begin
          if (t_q == T_LAST) begin
            state_q <= S_DRAIN;
            drain_q <= DRAIN_LOAD;
          end else begin
            t_q          <= step_d;
            out_left_q   <= skew_left;
            out_top_q    <= skew_top;
            feed_valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_left_o   = out_left_q;
  assign out_top_o    = out_top_q;
  assign feed_valid_o = feed_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
